uart_reg_arbiter: RTL

UART_REG_ARBITER -- requirements
Module: uart_reg_arbiter

---
 rtl/uart_reg_arbiter_pkg.sv | 37 +++
 rtl/uart_reg_arbiter_select.sv | 49 ++++
 rtl/uart_reg_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_reg_arbiter_pkg
// Shared definitions for the two-requester register-bus arbiter:
//   - FSM state encoding (IDLE / ACCESS / DONE)
//   - requester index constants
//   - register-map offsets of the attached UART register file
//   - helper for the consecutive-lock counter
// ---------------------------------------------------------------------------
package uart_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic REQ_IDX0 = 1'b0;
  localparam logic REQ_IDX1 = 1'b1;

  localparam logic [3:0] CNTRL0   = 4'd0;
  localparam logic [3:0] CNTRL1   = 4'd4;
  localparam logic [3:0] DATA_REG = 4'd8;

  // A locked grant to the same owner extends the run; any other locked grant
  // starts a fresh run of one.
  function automatic logic [3:0] lock_count_next(input logic       same_owner,
                                                 input logic [3:0] cnt);
    logic [3:0] nxt;
    if (same_owner) begin
      nxt = cnt + 4'd1;
    end else begin
      nxt = 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/uart_reg_arbiter_select.sv
// ---------------------------------------------------------------------------
// uart_arb_select
// Combinational winner selection for the register-bus arbiter.
// Ports:
//   req0, req1   in  : pending requests
//   last_gnt     in  : requester granted most recently (round-robin pointer)
//   lock_active  in  : previous grant asked to keep the bus
//   lock_owner   in  : requester that holds the lock
//   gnt_valid    out : at least one request is present
//   gnt_idx      out : index of the winning requester
// Parameter PRIO_MODE: 0 = round-robin, 1 = fixed priority (requester 0 wins).
// ---------------------------------------------------------------------------
module uart_arb_select
  import uart_reg_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  input  logic lock_active,
  input  logic lock_owner,
  output logic gnt_valid,
  output logic gnt_idx
);

  logic owner_req;

  // Lock owner first (only if it is asking), then the configured policy.
  always_comb begin
    owner_req = lock_owner ? req1 : req0;
    gnt_valid = req0 | req1;
    gnt_idx   = REQ_IDX0;
    if (lock_active && owner_req) begin
      gnt_idx = lock_owner;
    end else if (req0 && req1) begin
      if (PRIO_MODE != 0) begin
        gnt_idx = REQ_IDX0;
      end else begin
        gnt_idx = ~last_gnt;
      end
    end else if (req1) begin
      gnt_idx = REQ_IDX1;
    end else begin
      gnt_idx = REQ_IDX0;
    end
  end

endmodule

// File: rtl/uart_reg_arbiter.sv
// ---------------------------------------------------------------------------
// uart_reg_arbiter
// Arbitrates two requesters onto a single register-file bus. Each transaction
// takes three cycles: IDLE (arbitrate + capture fields), ACCESS (one cs
// strobe, read data captured), DONE (one-cycle ack to the winner).
// Ports:
//   clk, reset_n                  : clock, synchronous active-low reset
//   reqN/req_wenN/req_lockN       : request, write enable, keep-grant flag
//   req_addrN/req_wdataN          : request address / write data
//   ackN, rsp_rdataN              : completion pulse and read data
//   cs, wen, addr, wdata          : register-file bus (registered)
//   rdata                         : register-file read data (same cycle as cs)
//   busy                          : high whenever the FSM is not in IDLE
// Parameters: PRIO_MODE (0 round-robin, 1 fixed), MAX_LOCK (1..15).
// ---------------------------------------------------------------------------
module uart_reg_arbiter
  import uart_reg_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int MAX_LOCK  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        req_wen0,
  input  logic        req_wen1,
  input  logic        req_lock0,
  input  logic        req_lock1,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rsp_rdata0,
  output logic [31:0] rsp_rdata1,
  output logic        cs,
  output logic        wen,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  arb_state_e  state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        lock_q, lock_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;
  logic        cs_q, cs_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [31:0] rsp0_q, rsp0_d;
  logic [31:0] rsp1_q, rsp1_d;
  logic        busy_q, busy_d;

  logic        sel_valid;
  logic        sel_idx;
  logic        win_lock;
  logic [3:0]  cnt_next;
  logic [31:0] rdata_cap;

  uart_arb_select #(
    .PRIO_MODE (PRIO_MODE)
  ) u_select (
    .req0        (req0),
    .req1        (req1),
    .last_gnt    (last_q),
    .lock_active (lock_q),
    .lock_owner  (gnt_q),
    .gnt_valid   (sel_valid),
    .gnt_idx     (sel_idx)
  );

  // Next-state, datapath and lock bookkeeping.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    lock_d     = lock_q;
    lock_cnt_d = lock_cnt_q;
    cs_d       = 1'b0;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rsp0_d     = rsp0_q;
    rsp1_d     = rsp1_q;
    win_lock   = sel_idx ? req_lock1 : req_lock0;
    cnt_next   = lock_count_next(lock_q && (gnt_q == sel_idx), lock_cnt_q);
    rdata_cap  = wen_q ? 32'd0 : rdata;

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = ACCESS;
          gnt_d   = sel_idx;
          cs_d    = 1'b1;
          wen_d   = sel_idx ? req_wen1   : req_wen0;
          addr_d  = sel_idx ? req_addr1  : req_addr0;
          wdata_d = sel_idx ? req_wdata1 : req_wdata0;
          if (win_lock) begin
            // Reaching the limit ends the run so the other side gets a turn.
            if (cnt_next >= MAX_LOCK_C) begin
              lock_d     = 1'b0;
              lock_cnt_d = 4'd0;
            end else begin
              lock_d     = 1'b1;
              lock_cnt_d = cnt_next;
            end
          end else begin
            lock_d     = 1'b0;
            lock_cnt_d = 4'd0;
          end
        end else begin
          // Lock owner went quiet: drop the lock.
          state_d    = IDLE;
          lock_d     = 1'b0;
          lock_cnt_d = 4'd0;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (gnt_q) begin
          ack1_d = 1'b1;
          rsp1_d = rdata_cap;
        end else begin
          ack0_d = 1'b1;
          rsp0_d = rdata_cap;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = gnt_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_q      <= REQ_IDX0;
      last_q     <= REQ_IDX1;
      lock_q     <= 1'b0;
      lock_cnt_q <= 4'd0;
      cs_q       <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rsp0_q     <= 32'd0;
      rsp1_q     <= 32'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
      cs_q       <= cs_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
      busy_q     <= busy_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rsp_rdata0 = rsp0_q;
  assign rsp_rdata1 = rsp1_q;
  assign cs         = cs_q;
  assign wen        = wen_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign busy       = busy_q;

endmodule
